// File: rtl/gate_mon_pkg.sv
// Shared types and default constants for the gate output monitor.
package gate_mon_pkg;

  localparam int STABLE_CYC_DEF = 4;
  localparam int CNT_W_DEF      = 8;
  // Wide enough for the largest legal STABLE_CYC (255).
  localparam int QUAL_W         = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } monState_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_out_monitor.sv
// Debounces a glitchy gate output, counts accepted edges and rejected pulses,
// and offers one buffered edge event. Define GATE_MON_GLITCH_CNT_EN for glitch_cnt.
module gate_out_monitor
  import gate_mon_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             clr,
  output logic             y_filt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             evt_valid,
  output logic             evt_edge,
  input  logic             evt_ready,
  output logic             evt_ovf
);

  localparam logic [QUAL_W-1:0] QUAL_DONE = QUAL_W'(STABLE_CYC);
  localparam logic [QUAL_W-1:0] QUAL_ONE  = QUAL_W'(1);

  monState_t         state, stateNext;
  logic [QUAL_W-1:0] qualCnt, qualNext, qualInc;
  logic              s;
  logic              accept, glitch, riseEvt, fallEvt;
  logic              handshake, drop;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  sync_2ff uSync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (y_in),
    .q    (s)
  );

  assign qualInc = qualCnt + QUAL_ONE;

  // A level is accepted once the run of s at the new level reaches QUAL_DONE;
  // the entry cycle already counts as 1, so QUAL_DONE==1 skips QUAL_x entirely.
  always_comb begin
    stateNext = state;
    qualNext  = qualCnt;
    accept    = 1'b0;
    glitch    = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          if (QUAL_DONE == QUAL_ONE) begin
            stateNext = STABLE_HI;
            qualNext  = '0;
            accept    = 1'b1;
          end else begin
            stateNext = QUAL_HI;
            qualNext  = QUAL_ONE;
          end
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (QUAL_DONE == QUAL_ONE) begin
            stateNext = STABLE_LO;
            qualNext  = '0;
            accept    = 1'b1;
          end else begin
            stateNext = QUAL_LO;
            qualNext  = QUAL_ONE;
          end
        end
      end
      QUAL_HI: begin
        if (s) begin
          if (qualInc == QUAL_DONE) begin
            stateNext = STABLE_HI;
            qualNext  = '0;
            accept    = 1'b1;
          end else begin
            qualNext  = qualInc;
          end
        end else begin
          stateNext = STABLE_LO;
          qualNext  = '0;
          glitch    = 1'b1;
        end
      end
      QUAL_LO: begin
        if (!s) begin
          if (qualInc == QUAL_DONE) begin
            stateNext = STABLE_LO;
            qualNext  = '0;
            accept    = 1'b1;
          end else begin
            qualNext  = qualInc;
          end
        end else begin
          stateNext = STABLE_HI;
          qualNext  = '0;
          glitch    = 1'b1;
        end
      end
      default: begin
        stateNext = STABLE_LO;
        qualNext  = '0;
      end
    endcase
  end

  assign riseEvt = accept & (stateNext == STABLE_HI);
  assign fallEvt = accept & (stateNext == STABLE_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STABLE_LO;
      qualCnt <= '0;
      y_filt  <= 1'b0;
    end else begin
      state   <= stateNext;
      qualCnt <= qualNext;
      y_filt  <= y_filt ^ accept;
    end
  end

  // Single-entry event buffer: a consumer taking the old event on the same
  // edge frees the slot, so only an unconsumed buffer causes a drop.
  assign handshake = evt_valid & evt_ready;
  assign drop      = accept & evt_valid & ~evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_edge  <= 1'b0;
    end else if (accept && !drop) begin
      evt_valid <= 1'b1;
      evt_edge  <= riseEvt;
    end else if (handshake) begin
      evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      evt_ovf  <= 1'b0;
    end else if (clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      evt_ovf  <= 1'b0;
    end else begin
      rise_cnt <= satInc(rise_cnt, riseEvt);
      fall_cnt <= satInc(fall_cnt, fallEvt);
      if (drop) evt_ovf <= 1'b1;
    end
  end

`ifdef GATE_MON_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (clr) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= satInc(glitch_cnt, glitch);
    end
  end
`else
  logic unusedGlitch;
  assign unusedGlitch = glitch;
  assign glitch_cnt   = '0;
`endif

endmodule

// File: tb/tb_gate_out_monitor.sv
// Directed and randomized checks of gate_out_monitor against a run-length model.
module tb_gate_out_monitor;

  localparam int SC_A = 4;
  localparam int CW_A = 8;
  localparam int SC_B = 1;
  localparam int CW_B = 2;
`ifdef GATE_MON_GLITCH_CNT_EN
  localparam bit GL_EN = 1'b1;
`else
  localparam bit GL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic y_in = 1'b0;
  logic clr = 1'b0;
  logic evt_ready = 1'b0;
  logic chkEn = 1'b0;

  logic            yFiltA, validA, edgeA, ovfA;
  logic [CW_A-1:0] riseA, fallA, glA;
  logic            yFiltB, validB, edgeB, ovfB;
  logic [CW_B-1:0] riseB, fallB, glB;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  gate_out_monitor #(.STABLE_CYC(SC_A), .CNT_W(CW_A)) dutA (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .clr(clr), .y_filt(yFiltA),
    .rise_cnt(riseA), .fall_cnt(fallA), .glitch_cnt(glA), .evt_valid(validA),
    .evt_edge(edgeA), .evt_ready(evt_ready), .evt_ovf(ovfA)
  );

  gate_out_monitor #(.STABLE_CYC(SC_B), .CNT_W(CW_B)) dutB (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .clr(clr), .y_filt(yFiltB),
    .rise_cnt(riseB), .fall_cnt(fallB), .glitch_cnt(glB), .evt_valid(validB),
    .evt_edge(edgeB), .evt_ready(evt_ready), .evt_ovf(ovfB)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, the filtered level flips once s has differed from it
  // for SC consecutive samples; a shorter run that ends is a glitch.
  int mSc[2]  = '{SC_A, SC_B};
  int mMax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  bit mS1[2], mS2[2], mFilt[2], mVal[2], mEdge[2], mOvf[2];
  int mRun[2], mRise[2], mFall[2], mGl[2];

  initial begin
    bit acc, hs;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          mS1[i] = 0; mS2[i] = 0; mFilt[i] = 0; mVal[i] = 0; mEdge[i] = 0; mOvf[i] = 0;
          mRun[i] = 0; mRise[i] = 0; mFall[i] = 0; mGl[i] = 0;
        end else begin
          acc = 0;
          hs  = mVal[i] && evt_ready;
          if (mS2[i] != mFilt[i]) begin
            mRun[i]++;
            if (mRun[i] >= mSc[i]) begin
              mFilt[i] = mS2[i];
              mRun[i]  = 0;
              acc      = 1;
            end
          end else if (mRun[i] > 0) begin
            mRun[i] = 0;
            if (mGl[i] < mMax[i]) mGl[i]++;
          end
          if (acc) begin
            if (mFilt[i]) begin if (mRise[i] < mMax[i]) mRise[i]++; end
            else          begin if (mFall[i] < mMax[i]) mFall[i]++; end
            if (!mVal[i] || hs) begin
              mVal[i]  = 1;
              mEdge[i] = mFilt[i];
            end else begin
              mOvf[i] = 1;
            end
          end else if (hs) begin
            mVal[i] = 0;
          end
          if (clr) begin
            mRise[i] = 0; mFall[i] = 0; mGl[i] = 0; mOvf[i] = 0;
          end
          mS2[i] = mS1[i];
          mS1[i] = y_in;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chkEn) begin
      cmp("A.y_filt", yFiltA, mFilt[0]);
      cmp("A.rise_cnt", riseA, mRise[0]);
      cmp("A.fall_cnt", fallA, mFall[0]);
      cmp("A.glitch_cnt", glA, GL_EN ? mGl[0] : 0);
      cmp("A.evt_valid", validA, mVal[0]);
      if (mVal[0]) cmp("A.evt_edge", edgeA, mEdge[0]);
      cmp("A.evt_ovf", ovfA, mOvf[0]);
      cmp("B.y_filt", yFiltB, mFilt[1]);
      cmp("B.rise_cnt", riseB, mRise[1]);
      cmp("B.fall_cnt", fallB, mFall[1]);
      cmp("B.glitch_cnt", glB, GL_EN ? mGl[1] : 0);
      cmp("B.evt_valid", validB, mVal[1]);
      if (mVal[1]) cmp("B.evt_edge", edgeB, mEdge[1]);
      cmp("B.evt_ovf", ovfB, mOvf[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZeroA(input string tag);
    cmp({tag, ".y_filt"}, yFiltA, 0);
    cmp({tag, ".rise"}, riseA, 0);
    cmp({tag, ".fall"}, fallA, 0);
    cmp({tag, ".glitch"}, glA, 0);
    cmp({tag, ".valid"}, validA, 0);
    cmp({tag, ".edge"}, edgeA, 0);
    cmp({tag, ".ovf"}, ovfA, 0);
  endtask

  initial begin
    int runLeft;
    #1 rst_n = 1'b0;
    chkEn = 1'b1;
    #10 checkAllZeroA("reset");
    cmp("reset.B.valid", validB, 0);
    #11 rst_n = 1'b1;

    // Clean rise: y_filt must flip on the 6th edge counting the sampling edge.
    tick(3);
    y_in = 1'b1;
    tick(2);
    cmp("B.rise_lat_early", yFiltB, 0);
    tick(1);
    cmp("B.rise_lat", yFiltB, 1);
    tick(2);
    cmp("A.rise_lat_early", yFiltA, 0);
    tick(1);
    cmp("A.rise_lat", yFiltA, 1);
    cmp("A.rise_cnt1", riseA, 1);
    cmp("A.rise_valid", validA, 1);
    cmp("A.rise_edge", edgeA, 1);
    tick(4);
    evt_ready = 1'b1;
    tick(1);
    cmp("A.handshake_drop", validA, 0);

    y_in = 1'b0;
    tick(10);
    cmp("A.fall_cnt1", fallA, 1);
    cmp("A.fall_level", yFiltA, 0);

    // Three short pulses rejected by A.
    evt_ready = 1'b0;
    tick(2);
    repeat (3) begin
      y_in = 1'b1;
      tick(2);
      y_in = 1'b0;
      tick(6);
    end
    cmp("A.glitch_level", yFiltA, 0);
    cmp("A.glitch_rise", riseA, 1);
    cmp("A.glitch_cnt3", glA, GL_EN ? 3 : 0);
    cmp("A.glitch_noevt", validA, 0);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    cmp("A.clr_rise", riseA, 0);
    cmp("A.clr_fall", fallA, 0);
    cmp("B.clr_ovf", ovfB, 0);

    // Backpressure: the fall is dropped behind the buffered rise.
    y_in = 1'b1;
    tick(8);
    y_in = 1'b0;
    tick(8);
    cmp("A.bp_edge", edgeA, 1);
    cmp("A.bp_valid", validA, 1);
    cmp("A.bp_ovf", ovfA, 1);
    cmp("A.bp_fall", fallA, 1);
    evt_ready = 1'b1;
    tick(1);
    cmp("A.bp_drain", validA, 0);
    cmp("A.bp_ovf_sticky", ovfA, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    cmp("A.bp_ovf_clr", ovfA, 0);

    // Saturation on B (STABLE_CYC=1, CNT_W=2).
    tick(3);
    repeat (5) begin
      y_in = 1'b1;
      tick(3);
      y_in = 1'b0;
      tick(3);
    end
    cmp("B.sat_rise", riseB, 3);
    cmp("B.sat_fall", fallB, 3);
    y_in = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    cmp("B.clr_vs_rise", riseB, 0);
    cmp("B.clr_vs_rise_level", yFiltB, 1);

    // Reset while A is in QUAL_HI with count 3.
    y_in = 1'b0;
    tick(10);
    y_in = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2 checkAllZeroA("midqual_reset");
    #3 rst_n = 1'b1;
    tick(5);
    cmp("A.requal_early", yFiltA, 0);
    tick(1);
    cmp("A.requal", yFiltA, 1);
    cmp("A.requal_rise", riseA, 1);

    // Randomized traffic.
    runLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      if (runLeft == 0) begin
        y_in    = $urandom_range(0, 1);
        runLeft = $urandom_range(1, 9);
      end
      runLeft--;
      evt_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    clr = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/gate_out_monitor.md
GATE_OUT_MONITOR -- requirements
Module: gate_out_monitor

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter STABLE_CYC, default 4: consecutive synchronized cycles y_in must hold a new level before acceptance; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of all event counters.
REQ-004 Port clk, input, 1: sole clock, rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port y_in, input, 1: asynchronous output of the upstream gate network; may glitch.
REQ-007 Port clr, input, 1: synchronous clear of counters and the overflow flag.
REQ-008 Port y_filt, output, 1: debounced registered copy of y_in.
REQ-009 Port rise_cnt, output, CNT_W: accepted 0->1 transitions, saturating.
REQ-010 Port fall_cnt, output, CNT_W: accepted 1->0 transitions, saturating.
REQ-011 Port glitch_cnt, output, CNT_W: rejected pulses, saturating.
REQ-012 Port evt_valid, output, 1: event record available.
REQ-013 Port evt_edge, output, 1: event direction, 1=rise, 0=fall; valid only while evt_valid=1.
REQ-014 Port evt_ready, input, 1: consumer accepts event when evt_valid=1 and evt_ready=1 at a clock edge.
REQ-015 Port evt_ovf, output, 1: sticky flag, event lost.

Function
REQ-016 y_in SHALL pass through a 2-flop synchronizer; its output is called s.
REQ-017 FSM states SHALL be STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-018 In STABLE_LO, s=1 SHALL move to QUAL_HI with qual count=1.
REQ-018a In STABLE_HI, s=0 SHALL move to QUAL_LO with qual count=1.
REQ-019 In QUAL_x, s at the qualifying level SHALL increment the qual count.
REQ-019a When the qual count reaches STABLE_CYC, the FSM SHALL move to STABLE_x on that edge, toggle y_filt, and increment rise_cnt/fall_cnt.
REQ-020 In QUAL_x, s reverting before the qual count reaches STABLE_CYC SHALL return the FSM to the prior STABLE state, leave y_filt unchanged, and increment glitch_cnt.
REQ-021 Latency SHALL be: y_filt changes exactly STABLE_CYC+2 clocks after the first edge sampling the new y_in level (6 clocks at default).
REQ-022 With STABLE_CYC=1, the FSM SHALL pass through QUAL_x for zero cycles: STABLE_x to STABLE_x directly, latency 3.
REQ-023 On acceptance, evt_valid SHALL assert on the same edge y_filt toggles, with evt_edge set to the new y_filt value.
REQ-024 evt_valid and evt_edge SHALL hold until handshake; evt_valid SHALL drop on the edge after the handshake unless a new event is accepted on that same edge, in which case the new event loads and evt_valid stays 1.
REQ-025 A new event arriving while evt_valid=1 and evt_ready=0 SHALL be dropped (buffered event retained), set evt_ovf, and still update counters.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-027 clr SHALL zero all counters and evt_ovf on the next edge, take priority over a simultaneous increment or overflow, and leave the FSM, y_filt and the event buffer untouched.

Reset
REQ-028 rst_n=0 SHALL immediately force: FSM=STABLE_LO, synchronizer flops=0, qual count=0, y_filt=0, all counters=0, evt_valid=0, evt_edge=0, evt_ovf=0.
REQ-029 Reset mid-qualification or with a pending event SHALL discard both; deassertion SHALL be used only through the synchronous path, with no event generated for the reset itself.

Configuration
REQ-030 Macro GATE_MON_GLITCH_CNT_EN defined: glitch_cnt SHALL behave per REQ-020/026/027.
REQ-030a GATE_MON_GLITCH_CNT_EN undefined: the glitch_cnt port SHALL remain, tied to 0, with no counter logic; FSM behaviour is unchanged.

Structure
REQ-031 Shared package gate_mon_pkg SHALL hold the FSM state typedef and the default constants for STABLE_CYC and CNT_W.
REQ-032 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset to 0).

Verification
REQ-033 Clean rise: y_in 0->1 held 10 clocks -> y_filt=1 at clock 6, rise_cnt=1, evt_valid=1, evt_edge=1.
REQ-034 Glitch: y_in high for 2 clocks then low -> y_filt stays 0, glitch_cnt=1, no evt_valid.
REQ-035 Backpressure: evt_ready=0, rise then fall accepted -> evt_edge=1 retained, evt_ovf=1, fall_cnt=1.
REQ-036 Saturation/clr: CNT_W=2, 5 rises -> rise_cnt=3; clr coinciding with 6th rise -> rise_cnt=0.
REQ-037 Reset in QUAL_HI at count 3 -> all outputs 0; a later stable high qualifies in a fresh 6 clocks.
REQ-038 Macro off: 3 glitches -> glitch_cnt=0; all other results identical to macro on.
